apb_pwm_multi: RTL and testbench
================================

Name: apb_pwm_multi

Overview:
- Parametrised multi-channel successor to the single-channel APB PWM peripheral.
- APB3 slave with zero-wait-state register access and read-back.
- NUM_CH independent PWM channels with CNT_W-bit counters, per-channel polarity, and glitch-free shadowed period/duty updates.
- Sits on the peripheral APB bus; PWM_OUT drives pads or motor/LED logic directly.

Parameters:
- NUM_CH, 4, number of PWM channels (1..16).
- CNT_W, 16, counter/period/duty width in bits (2..32).
- ADDR_W, 8, PADDR width; PADDR is a word index, not a byte address.

Ports:
- PCLK  in  1  sole clock.
- PRESETn  in  1  asynchronous active-low reset.
- PADDR  in  ADDR_W  register word index.
- PWRITE  in  1  1 = write, 0 = read.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; valid in the access phase.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error on unmapped address.
- PWM_OUT  out  NUM_CH  per-channel PWM outputs.

Behaviour:
- Reset values, applied asynchronously on PRESETn low:
  - All registers, counters and shadows = 0.
  - PWM_OUT = 0, PRDATA = 0, PSLVERR = 0.
  - PREADY is driven 1.
- Register map (word index):
  - 0 CTRL: bits [NUM_CH-1:0] channel enable, RW.
  - 1 POL: bits [NUM_CH-1:0] invert output, RW.
  - 2+2c PERIOD_c: bits [CNT_W-1:0], RW.
  - 3+2c DUTY_c: bits [CNT_W-1:0], RW.
  - 2+2*NUM_CH STATUS: sticky period-wrap flags, write-1-to-clear.
  - Unused upper bits read 0; writes to them are ignored.
- APB timing:
  - PREADY = 1 always, so no wait states.
  - A write commits on the PCLK edge where PSEL & PENABLE & PWRITE are high.
  - PRDATA is combinational from PADDR when PSEL & !PWRITE; otherwise 0.
  - PSLVERR = PSEL & PENABLE & (PADDR > 2+2*NUM_CH).
  - Errored writes have no effect; errored reads return 0.
- Per-channel state:
  - cnt (CNT_W bits), period_sh, duty_sh.
- Channel disabled (CTRL bit 0):
  - cnt held at 0.
  - period_sh/duty_sh copy PERIOD/DUTY every cycle.
  - PWM_OUT[c] = POL[c], the inactive level.
- Channel enabled:
  - cnt increments each cycle.
  - When cnt == period_sh-1, cnt wraps to 0, shadows reload from PERIOD/DUTY, and STATUS[c] is set.
- Registered output:
  - PWM_OUT[c] <= (cnt < duty_sh) ^ POL[c].
  - First active output appears 1 cycle after the enable-write edge.
- Duty boundaries:
  - Each period gives exactly min(duty, period) high cycles (pre-polarity).
  - duty = 0 gives constant low.
  - duty >= period gives constant high.
- period_sh = 0:
  - cnt held at 0 and output inactive.
  - Shadows reload every cycle so a later nonzero PERIOD takes effect immediately.
- Writes to PERIOD/DUTY while enabled:
  - Not visible on the output until the next wrap.
  - Read-back returns the programmed value, not the shadow.
- Disabling mid-period:
  - cnt clears to 0 next edge; output goes inactive next edge.
- STATUS set and W1C clear in the same cycle: set wins.
- Reset mid-operation: everything returns to reset values immediately; no pending update survives.

Decomposition:
- Package apb_pwm_pkg holds:
  - Register index constants: CTRL_IDX = 0, POL_IDX = 1, CH_BASE = 2.
  - Function status_idx(NUM_CH).
  - Function ch_period_idx(c) and ch_duty_idx(c).
- One sub-module pwm_channel (parameter CNT_W):
  - Inputs: en, pol, period, duty.
  - Outputs: pwm_out, wrap_pulse.
  - Instantiated NUM_CH times via generate.
- Top level keeps the APB decode, register file and STATUS logic.

Test Plan:
- Shadowed single channel: PERIOD0 = 120, DUTY0 = 5, CTRL = 1 -> PWM_OUT[0] high 5 cycles, low 115, repeating; STATUS[0] sets after 120 cycles.
- Mid-period update: while running, write DUTY0 = 60 at cnt = 10 -> the current period still shows 5 high cycles; the next period shows 60 high / 60 low.
- Duty boundaries and polarity: DUTY1 = 0 -> constant 0; DUTY1 = 200 with PERIOD1 = 100 -> constant 1; POL = 2 -> channel 1 output inverted; disabled channel idles at its POL bit.
- Register access: write/read every register -> values match masked to CNT_W/NUM_CH bits; PADDR = 2+2*NUM_CH+1 -> PSLVERR = 1, PRDATA = 0, no state change.
- STATUS: wait for a wrap, then write 1 to STATUS[0] -> clears; a W1C landing on a wrap cycle -> bit stays 1.
- Reset mid-run: assert PRESETn low between clock edges with all channels active -> PWM_OUT = 0 and registers read 0 immediately; after release, outputs stay 0 until reprogrammed.

Source files
------------

// File: rtl/apb_pwm_pkg.sv
// ============================================================================
// Module      : apb_pwm_pkg
// Description : Register index constants and address helpers for apb_pwm_multi
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pwm_pkg;

  localparam int CTRL_IDX = 0;
  localparam int POL_IDX  = 1;
  localparam int CH_BASE  = 2;

  function automatic logic [31:0] status_idx(input int num_ch);
    return 32'(CH_BASE + 2 * num_ch);
  endfunction

  function automatic logic [31:0] ch_period_idx(input int c);
    return 32'(CH_BASE + 2 * c);
  endfunction

  function automatic logic [31:0] ch_duty_idx(input int c);
    return 32'(CH_BASE + 2 * c + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_pwm_multi_channel.sv
// ============================================================================
// Module      : pwm_channel
// Description : One PWM channel with shadowed period/duty and wrap pulse
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_channel #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pol,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  output logic             pwm_out,
  output logic             wrap_pulse
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] duty_sh;
  logic             running;
  logic             at_end;

  // A zero shadow period behaves like a disabled channel so new values load at once.
  assign running    = en & (period_sh != '0);
  assign at_end     = (cnt == period_sh - CNT_W'(1));
  assign wrap_pulse = running & at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      period_sh <= '0;
      duty_sh   <= '0;
      pwm_out   <= 1'b0;
    end else begin
      if (!running || at_end) begin
        cnt       <= '0;
        period_sh <= period;
        duty_sh   <= duty;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      pwm_out <= running ? ((cnt < duty_sh) ^ pol) : pol;
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_pwm_multi.sv
// ============================================================================
// Module      : apb_pwm_multi
// Description : APB3 slave with NUM_CH shadowed PWM channels and sticky wrap flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_pwm_multi
  import apb_pwm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PWRITE,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [NUM_CH-1:0] PWM_OUT
);

  logic [31:0]       addr;
  logic              addr_err;
  logic              wr_en;
  logic              ctrl_sel;
  logic              pol_sel;
  logic              status_sel;
  logic [NUM_CH-1:0] period_sel;
  logic [NUM_CH-1:0] duty_sel;
  logic [NUM_CH-1:0] ctrl;
  logic [NUM_CH-1:0] pol;
  logic [NUM_CH-1:0] status;
  logic [NUM_CH-1:0] status_clr;
  logic [NUM_CH-1:0] wrap;
  logic [CNT_W-1:0]  period [NUM_CH];
  logic [CNT_W-1:0]  duty   [NUM_CH];
  logic [31:0]       rdata;

  assign addr       = 32'(PADDR);
  assign addr_err   = (addr > status_idx(NUM_CH));
  assign ctrl_sel   = (addr == 32'(CTRL_IDX));
  assign pol_sel    = (addr == 32'(POL_IDX));
  assign status_sel = (addr == status_idx(NUM_CH));
  assign wr_en      = PSEL & PENABLE & PWRITE & ~addr_err;

  assign PREADY  = 1'b1;
  assign PSLVERR = PSEL & PENABLE & addr_err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ctrl <= '0;
      pol  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        period[c] <= '0;
        duty[c]   <= '0;
      end
    end else if (wr_en) begin
      if (ctrl_sel) ctrl <= PWDATA[NUM_CH-1:0];
      if (pol_sel)  pol  <= PWDATA[NUM_CH-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
        if (period_sel[c]) period[c] <= PWDATA[CNT_W-1:0];
        if (duty_sel[c])   duty[c]   <= PWDATA[CNT_W-1:0];
      end
    end
  end

  // A wrap on the same edge as a clear keeps the flag set.
  assign status_clr = (wr_en & status_sel) ? PWDATA[NUM_CH-1:0] : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      status <= '0;
    end else begin
      status <= (status & ~status_clr) | wrap;
    end
  end

  always_comb begin
    rdata = '0;
    if (ctrl_sel)   rdata = 32'(ctrl);
    if (pol_sel)    rdata = 32'(pol);
    if (status_sel) rdata = 32'(status);
    for (int c = 0; c < NUM_CH; c++) begin
      if (period_sel[c]) rdata = 32'(period[c]);
      if (duty_sel[c])   rdata = 32'(duty[c]);
    end
  end

  assign PRDATA = (PSEL & ~PWRITE) ? rdata : '0;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign period_sel[c] = (addr == ch_period_idx(c));
    assign duty_sel[c]   = (addr == ch_duty_idx(c));

    pwm_channel #(
      .CNT_W(CNT_W)
    ) u_channel (
      .clk       (PCLK),
      .rst_n     (PRESETn),
      .en        (ctrl[c]),
      .pol       (pol[c]),
      .period    (period[c]),
      .duty      (duty[c]),
      .pwm_out   (PWM_OUT[c]),
      .wrap_pulse(wrap[c])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_pwm_multi.sv
// ============================================================================
// Module      : tb_apb_pwm_multi
// Description : Scoreboard-driven bench for apb_pwm_multi
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_pwm_multi;

  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 16;
  localparam int ADDR_W     = 8;
  localparam int STATUS_IDX = 2 + 2 * NUM_CH;

  logic              PCLK    = 1'b0;
  logic              PRESETn = 1'b0;
  logic [ADDR_W-1:0] PADDR   = '0;
  logic              PWRITE  = 1'b0;
  logic              PSEL    = 1'b0;
  logic              PENABLE = 1'b0;
  logic [31:0]       PWDATA  = '0;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [NUM_CH-1:0] PWM_OUT;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0]       exp_q[$];
  logic [NUM_CH-1:0] pwm_q[$];

  apb_pwm_multi #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PADDR  (PADDR),
    .PWRITE (PWRITE),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR),
    .PWM_OUT(PWM_OUT)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Write commits on the second rising edge after a call made just past an edge.
  task automatic apb_write(input int addr, input logic [31:0] data, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = ADDR_W'(addr); PWDATA = data;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic reg_wr(input int addr, input logic [31:0] data);
    logic e;
    apb_write(addr, data, e);
  endtask

  task automatic apb_read(input int addr, output logic [31:0] data, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = ADDR_W'(addr);
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 data = PRDATA; err = PSLVERR;
    @(posedge PCLK);
    #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d, x;
    logic e;
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    checks++; if (PWM_OUT !== '0) begin failures++; $display("FAIL reset_pwm: got %h want 0", PWM_OUT); end
    checks++; if (PREADY !== 1'b1) begin failures++; $display("FAIL reset_pready: got %b want 1", PREADY); end
    checks++; if (PSLVERR !== 1'b0) begin failures++; $display("FAIL reset_pslverr: got %b want 0", PSLVERR); end
    checks++; if (PRDATA !== '0) begin failures++; $display("FAIL reset_prdata: got %h want 0", PRDATA); end
    PRESETn = 1'b1;
    for (int a = 0; a <= STATUS_IDX; a++) exp_q.push_back(32'h0);
    for (int a = 0; a <= STATUS_IDX; a++) begin
      apb_read(a, d, e);
      x = exp_q.pop_front();
      checks++; if (d !== x) begin failures++; $display("FAIL reset_reg[%0d]: got %h want %h", a, d, x); end
    end
  endtask

  task automatic test_register_access();
    logic [31:0] d, x;
    logic e;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hA);
    for (int c = 0; c < NUM_CH; c++) begin
      reg_wr(2 + 2 * c, 32'hDEAD_0100 + 32'(c));
      reg_wr(3 + 2 * c, 32'hBEEF_0200 + 32'(c));
      exp_q.push_back(32'h0000_0100 + 32'(c));
      exp_q.push_back(32'h0000_0200 + 32'(c));
    end
    exp_q.push_back(32'h0);
    apb_write(1, 32'hFFFF_FFFA, e);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL valid_wr_pslverr: got %b want 0", e); end
    reg_wr(0, 32'hFFFF_FFF0);
    reg_wr(STATUS_IDX, 32'hFFFF_FFFF);
    for (int a = 0; a <= STATUS_IDX; a++) begin
      apb_read(a, d, e);
      x = exp_q.pop_front();
      checks++; if (d !== x) begin failures++; $display("FAIL readback[%0d]: got %h want %h", a, d, x); end
    end
    reg_wr(0, 32'h0000_0035);
    exp_q.push_back(32'h5);
    apb_read(0, d, e);
    x = exp_q.pop_front();
    checks++; if (d !== x) begin failures++; $display("FAIL ctrl_mask: got %h want %h", d, x); end
    reg_wr(0, 32'h0);
    apb_write(STATUS_IDX + 1, 32'hFFFF_FFFF, e);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL err_wr_pslverr: got %b want 1", e); end
    apb_read(STATUS_IDX + 1, d, e);
    checks++; if (d !== 32'h0 || e !== 1'b1) begin failures++; $display("FAIL err_rd: got data %h err %b want 0 1", d, e); end
    apb_read(255, d, e);
    checks++; if (d !== 32'h0 || e !== 1'b1) begin failures++; $display("FAIL err_rd_top: got data %h err %b want 0 1", d, e); end
    exp_q.push_back(32'hA);
    exp_q.push_back(32'h0000_0100);
    apb_read(1, d, e);
    x = exp_q.pop_front();
    checks++; if (d !== x) begin failures++; $display("FAIL err_nochange_pol: got %h want %h", d, x); end
    apb_read(2, d, e);
    x = exp_q.pop_front();
    checks++; if (d !== x) begin failures++; $display("FAIL err_nochange_period0: got %h want %h", d, x); end
    reg_wr(1, 32'h0);
    reg_wr(STATUS_IDX, 32'hF);
  endtask

  task automatic test_single_channel();
    logic [NUM_CH-1:0] ep;
    logic [31:0] x;
    reg_wr(0, 32'h0);
    reg_wr(2, 32'd120);
    reg_wr(3, 32'd5);
    reg_wr(STATUS_IDX, 32'hF);
    reg_wr(0, 32'h1);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = ADDR_W'(STATUS_IDX);
    for (int k = 0; k < 250; k++) begin
      ep = '0;
      ep[0] = (k != 0) && (((k - 1) % 120) < 5);
      pwm_q.push_back(ep);
      exp_q.push_back((k >= 120) ? 32'h1 : 32'h0);
    end
    for (int k = 0; k < 250; k++) begin
      @(negedge PCLK);
      ep = pwm_q.pop_front();
      x  = exp_q.pop_front();
      checks++; if (PWM_OUT !== ep) begin failures++; $display("FAIL single_pwm k=%0d: got %b want %b", k, PWM_OUT, ep); end
      checks++; if (PRDATA !== x) begin failures++; $display("FAIL single_status k=%0d: got %h want %h", k, PRDATA, x); end
    end
    PSEL = 1'b0;
  endtask

  task automatic test_mid_period_update();
    logic [NUM_CH-1:0] ep;
    reg_wr(0, 32'h0);
    reg_wr(3, 32'd5);
    reg_wr(0, 32'h1);
    for (int k = 0; k < 360; k++) begin
      ep = '0;
      if (k >= 1 && k <= 120) ep[0] = ((k - 1) < 5);
      else if (k > 120)       ep[0] = (((k - 1) % 120) < 60);
      pwm_q.push_back(ep);
    end
    fork
      begin
        logic [NUM_CH-1:0] e1;
        for (int k = 0; k < 360; k++) begin
          @(negedge PCLK);
          e1 = pwm_q.pop_front();
          checks++; if (PWM_OUT !== e1) begin failures++; $display("FAIL midupd_pwm k=%0d: got %b want %b", k, PWM_OUT, e1); end
        end
      end
      begin
        logic [31:0] d, x;
        logic e;
        repeat (10) @(negedge PCLK);
        reg_wr(3, 32'd60);
        exp_q.push_back(32'd60);
        apb_read(3, d, e);
        x = exp_q.pop_front();
        checks++; if (d !== x) begin failures++; $display("FAIL midupd_readback: got %h want %h", d, x); end
      end
    join
  endtask

  task automatic test_duty_polarity();
    logic [NUM_CH-1:0] ep;
    reg_wr(0, 32'h0);
    reg_wr(4, 32'd100);
    reg_wr(5, 32'd0);
    reg_wr(0, 32'h2);
    for (int k = 0; k < 250; k++) pwm_q.push_back(4'b0000);
    for (int k = 0; k < 250; k++) begin
      @(negedge PCLK);
      ep = pwm_q.pop_front();
      checks++; if (PWM_OUT !== ep) begin failures++; $display("FAIL duty0 k=%0d: got %b want %b", k, PWM_OUT, ep); end
    end
    reg_wr(0, 32'h0);
    reg_wr(5, 32'd200);
    reg_wr(0, 32'h2);
    for (int k = 0; k < 250; k++) pwm_q.push_back((k == 0) ? 4'b0000 : 4'b0010);
    for (int k = 0; k < 250; k++) begin
      @(negedge PCLK);
      ep = pwm_q.pop_front();
      checks++; if (PWM_OUT !== ep) begin failures++; $display("FAIL duty_full k=%0d: got %b want %b", k, PWM_OUT, ep); end
    end
    reg_wr(1, 32'h2);
    for (int k = 0; k < 50; k++) pwm_q.push_back((k == 0) ? 4'b0010 : 4'b0000);
    for (int k = 0; k < 50; k++) begin
      @(negedge PCLK);
      ep = pwm_q.pop_front();
      checks++; if (PWM_OUT !== ep) begin failures++; $display("FAIL pol_inv k=%0d: got %b want %b", k, PWM_OUT, ep); end
    end
    reg_wr(1, 32'h5);
    for (int k = 0; k < 50; k++) pwm_q.push_back((k == 0) ? 4'b0000 : 4'b0111);
    for (int k = 0; k < 50; k++) begin
      @(negedge PCLK);
      ep = pwm_q.pop_front();
      checks++; if (PWM_OUT !== ep) begin failures++; $display("FAIL pol_idle k=%0d: got %b want %b", k, PWM_OUT, ep); end
    end
    reg_wr(0, 32'h0);
    reg_wr(1, 32'h0);
  endtask

  task automatic test_status_w1c();
    logic [31:0] d, x;
    logic e;
    int en_cyc;
    reg_wr(0, 32'h0);
    reg_wr(STATUS_IDX, 32'hF);
    exp_q.push_back(32'h0);
    apb_read(STATUS_IDX, d, e);
    x = exp_q.pop_front();
    checks++; if (d !== x) begin failures++; $display("FAIL status_cleared_init: got %h want %h", d, x); end
    reg_wr(2, 32'd20);
    reg_wr(3, 32'd3);
    reg_wr(0, 32'h1);
    en_cyc = cyc;
    wait_until(en_cyc + 24);
    exp_q.push_back(32'h1);
    apb_read(STATUS_IDX, d, e);
    x = exp_q.pop_front();
    checks++; if (d !== x) begin failures++; $display("FAIL status_set: got %h want %h", d, x); end
    wait_until(en_cyc + 46);
    reg_wr(STATUS_IDX, 32'h1);
    exp_q.push_back(32'h0);
    apb_read(STATUS_IDX, d, e);
    x = exp_q.pop_front();
    checks++; if (d !== x) begin failures++; $display("FAIL status_w1c: got %h want %h", d, x); end
    wait_until(en_cyc + 58);
    reg_wr(STATUS_IDX, 32'h1);
    exp_q.push_back(32'h1);
    apb_read(STATUS_IDX, d, e);
    x = exp_q.pop_front();
    checks++; if (d !== x) begin failures++; $display("FAIL status_set_wins: got %h want %h", d, x); end
    reg_wr(0, 32'h0);
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d, x;
    logic [NUM_CH-1:0] ep;
    logic e;
    for (int c = 0; c < NUM_CH; c++) begin
      reg_wr(2 + 2 * c, 32'd10);
      reg_wr(3 + 2 * c, 32'd4);
    end
    reg_wr(0, 32'hF);
    exp_q.push_back(32'hF);
    apb_read(0, d, e);
    x = exp_q.pop_front();
    checks++; if (d !== x) begin failures++; $display("FAIL pre_reset_ctrl: got %h want %h", d, x); end
    repeat (7) @(posedge PCLK);
    #3 PRESETn = 1'b0;
    #1;
    checks++; if (PWM_OUT !== '0) begin failures++; $display("FAIL async_reset_pwm: got %b want 0", PWM_OUT); end
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = ADDR_W'(0);
    #1;
    checks++; if (PRDATA !== '0) begin failures++; $display("FAIL async_reset_ctrl: got %h want 0", PRDATA); end
    PADDR = ADDR_W'(2);
    #1;
    checks++; if (PRDATA !== '0) begin failures++; $display("FAIL async_reset_period0: got %h want 0", PRDATA); end
    @(negedge PCLK);
    PSEL = 1'b0;
    PRESETn = 1'b1;
    for (int k = 0; k < 30; k++) pwm_q.push_back('0);
    for (int k = 0; k < 30; k++) begin
      @(negedge PCLK);
      ep = pwm_q.pop_front();
      checks++; if (PWM_OUT !== ep) begin failures++; $display("FAIL post_reset_pwm k=%0d: got %b want %b", k, PWM_OUT, ep); end
    end
    for (int a = 0; a <= STATUS_IDX; a++) exp_q.push_back(32'h0);
    for (int a = 0; a <= STATUS_IDX; a++) begin
      apb_read(a, d, e);
      x = exp_q.pop_front();
      checks++; if (d !== x) begin failures++; $display("FAIL post_reset_reg[%0d]: got %h want %h", a, d, x); end
    end
  endtask

  initial begin
    test_reset();
    test_register_access();
    test_single_channel();
    test_mid_period_update();
    test_duty_polarity();
    test_status_w1c();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
